// File: rtl/led_status_gen.sv
// LED mode generator: turns per-channel link/activity/error status into
// sixteen registered 2-bit LED codes (00 off, 01 slow, 10 fast, 11 on).
module led_status_gen #(
  parameter int CLK_PERIOD_NS   = 10,
  parameter int SIM_TICK_CYCLES = 0,
  parameter int ACT_HOLD_MS     = 50,
  parameter int ERR_HOLD_MS     = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] link_up,
  input  logic [7:0] act_pulse,
  input  logic [7:0] err_pulse,
  input  logic [7:0] err_clr,
  input  logic       lamp_test,
  output logic [1:0] led0,
  output logic [1:0] led1,
  output logic [1:0] led2,
  output logic [1:0] led3,
  output logic [1:0] led4,
  output logic [1:0] led5,
  output logic [1:0] led6,
  output logic [1:0] led7,
  output logic [1:0] led8,
  output logic [1:0] led9,
  output logic [1:0] led10,
  output logic [1:0] led11,
  output logic [1:0] led12,
  output logic [1:0] led13,
  output logic [1:0] led14,
  output logic [1:0] led15
);

  localparam int TICK_N = (SIM_TICK_CYCLES != 0) ? SIM_TICK_CYCLES
                                                 : (1000000 / CLK_PERIOD_NS);
  localparam int PW = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam int AW = $clog2(ACT_HOLD_MS + 1);
  localparam int EW = $clog2(ERR_HOLD_MS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_N - 1);
  localparam logic [AW-1:0] ACT_LOAD = AW'(ACT_HOLD_MS);
  localparam logic [EW-1:0] ERR_LOAD = EW'(ERR_HOLD_MS);

  localparam logic [1:0] LED_OFF  = 2'b00;
  localparam logic [1:0] LED_SLOW = 2'b01;
  localparam logic [1:0] LED_FAST = 2'b10;
  localparam logic [1:0] LED_ON   = 2'b11;

  // ---------------------------------------------------------------
  // 1 ms tick prescaler
  // ---------------------------------------------------------------
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Per-channel hold counters, sticky error flags, link register
  // ---------------------------------------------------------------
  logic [AW-1:0] act_cnt [8];
  logic [AW-1:0] act_nxt [8];
  logic [EW-1:0] err_cnt [8];
  logic [EW-1:0] err_nxt [8];
  logic [7:0]    sticky;
  logic [7:0]    sticky_nxt;
  logic [7:0]    link_q;

  // A pulse reloads the counter even on a tick edge, so a pulse never
  // loses a tick of hold time to an unlucky alignment.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      act_nxt[i] = act_cnt[i];
      err_nxt[i] = err_cnt[i];
      if (act_pulse[i]) begin
        act_nxt[i] = ACT_LOAD;
      end else if (tick && (act_cnt[i] != '0)) begin
        act_nxt[i] = act_cnt[i] - 1'b1;
      end
      if (err_pulse[i]) begin
        err_nxt[i] = ERR_LOAD;
      end else if (tick && (err_cnt[i] != '0)) begin
        err_nxt[i] = err_cnt[i] - 1'b1;
      end
    end
  end

  // Set wins over clear when both strobes land together.
  always_comb begin
    sticky_nxt = (sticky & ~err_clr) | err_pulse;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        act_cnt[i] <= '0;
        err_cnt[i] <= '0;
      end
      sticky <= '0;
      link_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        act_cnt[i] <= act_nxt[i];
        err_cnt[i] <= err_nxt[i];
      end
      sticky <= sticky_nxt;
      link_q <= link_up;
    end
  end

  // ---------------------------------------------------------------
  // Output code register; lamp test overrides without disturbing state
  // ---------------------------------------------------------------
  logic [1:0] led_q   [16];
  logic [1:0] led_nxt [16];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (!link_q[i]) begin
        led_nxt[2*i] = LED_OFF;
      end else if (act_cnt[i] != '0) begin
        led_nxt[2*i] = LED_FAST;
      end else begin
        led_nxt[2*i] = LED_ON;
      end
      if (err_cnt[i] != '0) begin
        led_nxt[2*i+1] = LED_FAST;
      end else if (sticky[i]) begin
        led_nxt[2*i+1] = LED_SLOW;
      end else begin
        led_nxt[2*i+1] = LED_OFF;
      end
    end
    if (lamp_test) begin
      for (int i = 0; i < 16; i++) begin
        led_nxt[i] = LED_ON;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        led_q[i] <= LED_OFF;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        led_q[i] <= led_nxt[i];
      end
    end
  end

  assign led0  = led_q[0];
  assign led1  = led_q[1];
  assign led2  = led_q[2];
  assign led3  = led_q[3];
  assign led4  = led_q[4];
  assign led5  = led_q[5];
  assign led6  = led_q[6];
  assign led7  = led_q[7];
  assign led8  = led_q[8];
  assign led9  = led_q[9];
  assign led10 = led_q[10];
  assign led11 = led_q[11];
  assign led12 = led_q[12];
  assign led13 = led_q[13];
  assign led14 = led_q[14];
  assign led15 = led_q[15];

endmodule

// File: tb/tb_led_status_gen.sv
// Bench for led_status_gen: a history-based model (tick arithmetic over
// pulse timestamps) checked every cycle, plus directed literal checks.
module tb_led_status_gen;

  localparam int N    = 10;
  localparam int AH   = 3;
  localparam int EH   = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] link_up, act_pulse, err_pulse, err_clr;
  logic       lamp_test;
  logic [1:0] led [16];
  logic [31:0] led_pk;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_status_gen #(
    .CLK_PERIOD_NS(10), .SIM_TICK_CYCLES(N),
    .ACT_HOLD_MS(AH), .ERR_HOLD_MS(EH)
  ) dut (
    .clk(clk), .rst(rst),
    .link_up(link_up), .act_pulse(act_pulse),
    .err_pulse(err_pulse), .err_clr(err_clr),
    .lamp_test(lamp_test),
    .led0(led[0]),   .led1(led[1]),   .led2(led[2]),   .led3(led[3]),
    .led4(led[4]),   .led5(led[5]),   .led6(led[6]),   .led7(led[7]),
    .led8(led[8]),   .led9(led[9]),   .led10(led[10]), .led11(led[11]),
    .led12(led[12]), .led13(led[13]), .led14(led[14]), .led15(led[15])
  );

  always_comb begin
    led_pk = '0;
    for (int i = 0; i < 16; i++) led_pk[2*i +: 2] = led[i];
  end

  // ---------------------------------------------------------------
  // Model: j is the index of the next edge since reset release. Tick
  // edges are those with j % N == N-1. A hold started at edge L is
  // still active after edge t while fewer than HOLD ticks fell in (L, t].
  // ---------------------------------------------------------------
  int          j = 0;
  bit          mvalid = 0;
  int          act_last [8];
  int          err_last [8];
  bit          stk [8];
  bit          lq [8];
  logic [31:0] exp_pk;

  function automatic bit held(input int last, input int t, input int hold);
    if (last < 0) return 1'b0;
    return (((t + 1) / N) - ((last + 1) / N)) < hold;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mvalid = 1'b1;
      exp_pk = '0;
      j = 0;
      for (int c = 0; c < 8; c++) begin
        act_last[c] = -1; err_last[c] = -1; stk[c] = 1'b0; lq[c] = 1'b0;
      end
    end else if (mvalid) begin
      for (int c = 0; c < 8; c++) begin
        logic [1:0] s, e;
        s = !lq[c] ? 2'b00 : (held(act_last[c], j - 1, AH) ? 2'b10 : 2'b11);
        e = held(err_last[c], j - 1, EH) ? 2'b10 : (stk[c] ? 2'b01 : 2'b00);
        exp_pk[4*c +: 2]     = lamp_test ? 2'b11 : s;
        exp_pk[4*c + 2 +: 2] = lamp_test ? 2'b11 : e;
      end
      for (int c = 0; c < 8; c++) begin
        lq[c] = link_up[c];
        if (act_pulse[c]) act_last[c] = j;
        if (err_pulse[c]) err_last[c] = j;
        if (err_pulse[c]) stk[c] = 1'b1;
        else if (err_clr[c]) stk[c] = 1'b0;
      end
      j = j + 1;
    end
  end

  // Per-cycle scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      n_vec++;
      if (led_pk !== exp_pk) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: got %h expected %h", $time, led_pk, exp_pk);
      end
    end
  end

  // ---------------------------------------------------------------
  // Driver / literal-check tasks
  // ---------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, req);
    end
  endtask

  task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
    n_vec++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    int e;
    int w;
    rst = 1'b1; link_up = '0; act_pulse = '0; err_pulse = '0;
    err_clr = '0; lamp_test = 1'b0;

    // Reset with inputs toggling
    repeat (3) begin
      @(negedge clk);
      link_up   = 8'($urandom_range(0, 255));
      act_pulse = 8'($urandom_range(0, 255));
      err_pulse = 8'($urandom_range(0, 255));
      err_clr   = 8'($urandom_range(0, 255));
      lamp_test = 1'($urandom_range(0, 1));
    end
    chk("reset_all_off", led_pk, 32'h0);
    rst = 1'b0; link_up = '0; act_pulse = '0; err_pulse = '0;
    err_clr = '0; lamp_test = 1'b0;
    cyc(1);
    chk("first_edge_after_release", led_pk, 32'h0);
    cyc(3);

    // Link up on channel 2
    link_up[2] = 1'b1;
    cyc(1);
    chk("link_one_edge", {30'b0, led[4]}, 32'h0);
    cyc(1);
    chk("link_on", {30'b0, led[4]}, 32'h3);

    // Single activity pulse and its stretch length
    act_pulse[2] = 1'b1;
    cyc(1);
    act_pulse[2] = 1'b0;
    cyc(1);
    chk("act_fast", {30'b0, led[4]}, 32'h2);
    d = 1;
    while (led[4] != 2'b11 && d < 60) begin
      cyc(1);
      d++;
    end
    chk_rng("act_hold_len", d, 21, 31);

    // Pulses every 15 cycles keep the LED in fast blink
    for (int p = 0; p < 6; p++) begin
      act_pulse[2] = 1'b1;
      cyc(1);
      act_pulse[2] = 1'b0;
      for (int k = 0; k < 14; k++) begin
        cyc(1);
        if (k == 0 || k == 13) chk("act_repeat", {30'b0, led[4]}, 32'h2);
      end
    end
    cyc(40);
    chk("act_expired", {30'b0, led[4]}, 32'h3);

    // Link down hides activity
    link_up[2] = 1'b0;
    act_pulse[2] = 1'b1;
    cyc(1);
    act_pulse[2] = 1'b0;
    cyc(1);
    chk("link_down_off", {30'b0, led[4]}, 32'h0);
    cyc(5);
    chk("link_down_off_hold", {30'b0, led[4]}, 32'h0);
    link_up[2] = 1'b1;
    cyc(40);

    // Single error pulse on channel 5
    err_pulse[5] = 1'b1;
    cyc(1);
    err_pulse[5] = 1'b0;
    cyc(1);
    e = 0;
    while (led[11] == 2'b10 && e < 80) begin
      e++;
      cyc(1);
    end
    chk_rng("err_hold_len", e, 41, 51);
    chk("err_sticky", {30'b0, led[11]}, 32'h1);
    cyc(20);
    chk("err_sticky_stays", {30'b0, led[11]}, 32'h1);

    err_clr[5] = 1'b1;
    cyc(1);
    err_clr[5] = 1'b0;
    cyc(1);
    chk("err_cleared", {30'b0, led[11]}, 32'h0);

    // Simultaneous set and clear keeps sticky
    err_pulse[5] = 1'b1; err_clr[5] = 1'b1;
    cyc(1);
    err_pulse[5] = 1'b0; err_clr[5] = 1'b0;
    cyc(1);
    chk("err_set_clr_fast", {30'b0, led[11]}, 32'h2);
    cyc(55);
    chk("err_set_clr_sticky", {30'b0, led[11]}, 32'h1);

    // Activity pulse landing exactly on a tick edge
    w = 0;
    while ((j % N) != N - 1 && w < 20) begin
      cyc(1);
      w++;
    end
    act_pulse[2] = 1'b1;
    cyc(1);
    act_pulse[2] = 1'b0;
    d = 0;
    do begin
      cyc(1);
      d++;
    end while (led[4] != 2'b11 && d < 60);
    chk("collision_hold_len", d, 31);

    // Lamp test over mixed state, dropped during an error hold
    lamp_test = 1'b1;
    cyc(1);
    chk("lamp_all_on", led_pk, 32'hFFFF_FFFF);
    err_pulse[0] = 1'b1;
    cyc(1);
    err_pulse[0] = 1'b0;
    cyc(20);
    chk("lamp_still_on", led_pk, 32'hFFFF_FFFF);
    lamp_test = 1'b0;
    cyc(1);
    chk("lamp_drop_err0", {30'b0, led[1]}, 32'h2);
    chk("lamp_drop_err5", {30'b0, led[11]}, 32'h1);
    chk("lamp_drop_link2", {30'b0, led[4]}, 32'h3);

    // Reset in the middle of holds and sticky flags
    link_up = 8'hFF; act_pulse = 8'hFF; err_pulse = 8'hFF;
    cyc(1);
    act_pulse = '0; err_pulse = '0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("midreset_off", led_pk, 32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("midreset_release_edge", led_pk, 32'h0);
    cyc(1);
    chk("midreset_link_on", led_pk, 32'h3333_3333);
    cyc(30);
    chk("midreset_steady", led_pk, 32'h3333_3333);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
